uart_tx_parity: RTL and testbench
=================================

// Module: uart_tx_parity
// PURPOSE
//  Byte-serial UART transmitter fed by the BRAM readout FSM (req/busy handshake, din = byte read from BRAM).
//  Frame is 11 bits: start(0), 8 data bits LSB first, parity bit (even or odd), stop(1).
//  Baud rate comes from a runtime 3-bit select against a fixed system clock.
//  Drives the board uart_txd pin directly.
// PARAMETERS
//  CLK_FREQ   50_000_000  system clock in Hz; divisor table is derived from it at elaboration
//  STOP_BITS  1           stop bits per frame (1 or 2); default frame is 11 bits
// PORTS
//  CLK_50M    in   1  system clock, single clock domain
//  rst_n      in   1  asynchronous, active-low reset
//  bps_sel    in   3  baud select: 0=300 1=1200 2=2400 3=4800 4=9600 5=19200 6=38400 7=115200
//  check_sel  in   1  parity: 0=even, 1=odd
//  din        in   8  byte to send
//  req        in   1  send request; rising edge launches one frame
//  busy       out  1  high while a frame is in flight
//  TX         out  1  serial line, idle high
// BEHAVIOUR
//  Reset (async assert, sync release): TX=1, busy=0, state IDLE, bit/baud counters 0, req_d=1.
//   req_d resets to 1 so a req held high across reset release does NOT launch a frame.
//  Launch: in IDLE, req && !req_d sampled at edge k -> din, bps_sel and check_sel latched.
//   At edge k+1: busy=1, TX=0 (start bit).
//  Level on req is ignored; req held high for any length sends exactly one frame.
//  A rising edge of req while busy=1 is dropped, not queued.
//  Bit period DIV = round(CLK_FREQ/baud).
//   At 50 MHz: 166667, 41667, 20833, 10417, 5208, 2604, 1302, 434 for sel 0..7.
//  Baud counter is 18 bits. It counts 0..DIV-1 and restarts at every bit boundary, so each bit lasts exactly DIV cycles.
//  FSM states:
//   IDLE   -> START  on launch
//   START  -> DATA   after DIV cycles
//   DATA   -> PARITY after 8 bits; 3-bit index, LSB first
//   PARITY -> STOP   after DIV cycles
//   STOP   -> IDLE   after STOP_BITS*DIV cycles
//  Parity bit = ^din_latched when check_sel=0 (even), ~^din_latched when check_sel=1 (odd).
//  busy drops in the same cycle TX returns to idle after the last stop bit.
//   Total busy = (10+STOP_BITS)*DIV cycles.
//  A new rising edge in the first cycle with busy=0 launches immediately (back-to-back frames, no gap beyond stop).
//  bps_sel/check_sel/din changes mid-frame have no effect on the current frame.
//  rst_n low mid-frame: TX=1 and busy=0 at once; the partial frame is abandoned; no resume after release.
//  TX and busy are registered outputs (glitch-free).
// STRUCTURE
//  Shared package/header uart_defs.vh:
//   - baud table localparams BAUD_0..BAUD_7
//   - DIV function of CLK_FREQ
//   - state encodings IDLE/START/DATA/PARITY/STOP
//   - PARITY_EVEN=0, PARITY_ODD=1
//  One sub-module: uart_baud_gen. It takes a latched divisor and a run enable and emits a 1-cycle bit_tick at each bit end.
//   The counter clears whenever run=0.
//  Top holds req edge detect, latches, FSM, bit index and TX/busy registers.
// TESTING (CLK_FREQ=50e6)
//  1. bps_sel=4, check_sel=0, din=8'h55, one req pulse:
//     TX = 0,1,0,1,0,1,0,1,0, parity 0, stop 1; each bit 5208 cycles; busy high 57288 cycles.
//  2. bps_sel=7, check_sel=1, din=8'hA7:
//     data bits 1,1,1,0,0,1,0,1, parity 0; bit period 434 cycles; busy high 4774 cycles.
//  3. req held high for 3 frame times, din=8'h3C:
//     exactly one frame; busy falls and stays low until req goes low then high again.
//  4. Second req rising edge at mid-data of frame 1:
//     ignored, one frame only. Edge in the first cycle after busy falls: frame 2 starts next cycle.
//  5. rst_n low during bit 4 of a frame:
//     TX=1 and busy=0 within the same cycle. After release with req held high: no frame until a fresh rising edge.
//  6. Change bps_sel 4->7 and din mid-frame:
//     current frame keeps 5208-cycle bits and the original data. Next frame uses 434 cycles.

Source files
------------

// File: rtl/uart_tx_parity_pkg.sv
// Shared definitions for the UART transmitter with parity.
//   - baud rate table (BAUD_0..BAUD_7) selected by the 3-bit bps_sel input
//   - div_of(): bit period in system clocks, rounded to nearest
//   - transmitter FSM states and parity select encodings
package uart_tx_parity_pkg;

  // Width of the baud counter / divisor; 166667 (300 baud @ 50 MHz) fits.
  localparam int unsigned DIV_W = 18;

  localparam int unsigned BAUD_0 = 300;
  localparam int unsigned BAUD_1 = 1200;
  localparam int unsigned BAUD_2 = 2400;
  localparam int unsigned BAUD_3 = 4800;
  localparam int unsigned BAUD_4 = 9600;
  localparam int unsigned BAUD_5 = 19200;
  localparam int unsigned BAUD_6 = 38400;
  localparam int unsigned BAUD_7 = 115200;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  // Bit period = round(clk_freq / baud). Elaboration-time use only.
  function automatic logic [DIV_W-1:0] div_of(input int unsigned clk_freq,
                                              input int unsigned baud);
    longint unsigned c;
    longint unsigned b;
    longint unsigned q;
    c = 64'(clk_freq);
    b = 64'(baud);
    q = (c + b / 64'd2) / b;
    return DIV_W'(q);
  endfunction

endpackage

// File: rtl/uart_tx_parity_baud_gen.sv
// Bit-period timer for the UART transmitter.
//   clk      system clock
//   rst_n    asynchronous active-low reset
//   run      counter runs while high, held at zero while low
//   div      bit period in clocks (latched by the caller for the whole frame)
//   bit_tick one-cycle pulse in the last clock of every bit period
module uart_baud_gen
  import uart_tx_parity_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [DIV_W-1:0] div,
  output logic             bit_tick
);

  logic [DIV_W-1:0] cnt;

  // Counts 0..div-1; the tick cycle is the last clock of the bit.
  assign bit_tick = run && (cnt == (div - DIV_W'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!run || bit_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_parity.sv
// Byte-serial UART transmitter with selectable baud rate and parity.
// Frame: start(0), 8 data bits LSB first, parity, STOP_BITS stop bits(1).
//   CLK_50M   system clock
//   rst_n     asynchronous active-low reset
//   bps_sel   baud select 0..7 = 300,1200,2400,4800,9600,19200,38400,115200
//   check_sel parity select, 0 = even, 1 = odd
//   din       byte to send, captured on launch
//   req       send request; a rising edge launches one frame
//   busy      high while a frame is in flight (registered)
//   TX        serial line, idle high (registered)
module uart_tx_parity
  import uart_tx_parity_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic       CLK_50M,
  input  logic       rst_n,
  input  logic [2:0] bps_sel,
  input  logic       check_sel,
  input  logic [7:0] din,
  input  logic       req,
  output logic       busy,
  output logic       TX
);

  localparam logic [DIV_W-1:0] DIV_TBL [8] = '{
    div_of(CLK_FREQ, BAUD_0), div_of(CLK_FREQ, BAUD_1),
    div_of(CLK_FREQ, BAUD_2), div_of(CLK_FREQ, BAUD_3),
    div_of(CLK_FREQ, BAUD_4), div_of(CLK_FREQ, BAUD_5),
    div_of(CLK_FREQ, BAUD_6), div_of(CLK_FREQ, BAUD_7)
  };

  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  tx_state_e        state_q;
  tx_state_e        state_d;
  logic             req_d;
  logic [7:0]       din_q;
  logic             check_q;
  logic [DIV_W-1:0] div_q;
  logic [2:0]       bit_idx;
  logic             bit_tick;
  logic             launch;
  logic             parity_bit;
  logic             tx_d;
  logic             busy_d;

  // busy is registered one cycle behind the state, so also gating on it drops
  // an edge arriving in the last cycle busy is still high.
  assign launch = (state_q == IDLE) && !busy && req && !req_d;

  assign parity_bit = (check_q == PARITY_ODD) ? ~^din_q : ^din_q;

  uart_baud_gen u_baud_gen (
    .clk      (CLK_50M),
    .rst_n    (rst_n),
    .run      (state_q != IDLE),
    .div      (div_q),
    .bit_tick (bit_tick)
  );

  // State register
  always_ff @(posedge CLK_50M or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (launch) state_d = START;
      START:   if (bit_tick) state_d = DATA;
      DATA:    if (bit_tick && (bit_idx == 3'd7)) state_d = PARITY;
      PARITY:  if (bit_tick) state_d = STOP;
      STOP:    if (bit_tick && (bit_idx == LAST_STOP)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode, registered below so TX/busy lag state by one clock
  always_comb begin
    tx_d   = 1'b1;
    busy_d = 1'b1;
    unique case (state_q)
      IDLE:    busy_d = 1'b0;
      START:   tx_d   = 1'b0;
      DATA:    tx_d   = din_q[bit_idx];
      PARITY:  tx_d   = parity_bit;
      STOP:    tx_d   = 1'b1;
      default: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK_50M or negedge rst_n) begin
    if (!rst_n) begin
      TX   <= 1'b1;
      busy <= 1'b0;
    end else begin
      TX   <= tx_d;
      busy <= busy_d;
    end
  end

  // Edge detector and per-frame latches. req_d resets high so a req held
  // across reset release is not seen as an edge.
  always_ff @(posedge CLK_50M or negedge rst_n) begin
    if (!rst_n) begin
      req_d   <= 1'b1;
      din_q   <= '0;
      check_q <= PARITY_EVEN;
      div_q   <= '0;
    end else begin
      req_d <= req;
      if (launch) begin
        din_q   <= din;
        check_q <= check_sel;
        div_q   <= DIV_TBL[bps_sel];
      end
    end
  end

  // Bit index within DATA and STOP; restarts on every state change.
  always_ff @(posedge CLK_50M or negedge rst_n) begin
    if (!rst_n) begin
      bit_idx <= '0;
    end else if (state_q == IDLE) begin
      bit_idx <= '0;
    end else if (bit_tick) begin
      bit_idx <= (state_d != state_q) ? 3'd0 : bit_idx + 3'd1;
    end
  end

endmodule

// File: tb/tb_uart_tx_parity.sv
// Directed self-checking bench for uart_tx_parity at CLK_FREQ = 50 MHz.
module tb_uart_tx_parity;

  logic       CLK_50M = 1'b0;
  logic       rst_n;
  logic [2:0] bps_sel;
  logic       check_sel;
  logic [7:0] din;
  logic       req;
  logic       busy;
  logic       TX;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #10 CLK_50M = ~CLK_50M;

  uart_tx_parity #(
    .CLK_FREQ  (50_000_000),
    .STOP_BITS (1)
  ) dut (
    .CLK_50M   (CLK_50M),
    .rst_n     (rst_n),
    .bps_sel   (bps_sel),
    .check_sel (check_sel),
    .din       (din),
    .req       (req),
    .busy      (busy),
    .TX        (TX)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick(input int unsigned n = 1);
    repeat (n) begin
      @(posedge CLK_50M);
      #1;
    end
  endtask

  task automatic count_busy(input int unsigned n, output int unsigned hi);
    hi = 0;
    repeat (n) begin
      tick();
      if (busy !== 1'b0) hi++;
    end
  endtask

  // Follows one frame from busy rising. exp_bits: [0]=start, [8:1]=data,
  // [9]=parity, [10]=stop. act 1 = change bps_sel/din/check_sel at act_cyc,
  // act 2 = pulse req at act_cyc.
  task automatic run_frame(input string tag, input int unsigned div,
                           input logic [10:0] exp_bits,
                           input int unsigned act_cyc, input int act);
    int unsigned c;
    int unsigned w;
    logic [10:0] got;
    got = '0;
    w = 0;
    while (busy !== 1'b1 && w < 20) begin
      tick();
      w++;
    end
    if (busy !== 1'b1) begin
      check({tag, "_launch"}, 32'(busy), 1);
      return;
    end
    c = 0;
    while (busy === 1'b1 && c < 12 * div) begin
      if ((c % div == div / 2) && (c / div < 11)) got[4'(c / div)] = TX;
      if (c == div - 1) check({tag, "_start_last"}, 32'(TX), 0);
      if (c == div)     check({tag, "_bit0_first"}, 32'(TX), 32'(exp_bits[1]));
      if (act == 1 && c == act_cyc) begin
        bps_sel   = 3'd7;
        din       = 8'hFF;
        check_sel = 1'b1;
      end
      if (act == 2 && c == act_cyc)     req = 1'b1;
      if (act == 2 && c == act_cyc + 4) req = 1'b0;
      tick();
      c++;
    end
    check({tag, "_busy_len"}, c, 11 * div);
    check({tag, "_bits"}, 32'(got), 32'(exp_bits));
    check({tag, "_tx_idle"}, 32'(TX), 1);
  endtask

  initial begin
    int unsigned hi;

    // Reset with req held high; release must not launch a frame.
    rst_n     = 1'b0;
    req       = 1'b1;
    bps_sel   = 3'd4;
    check_sel = 1'b0;
    din       = 8'h55;
    tick(3);
    check("rst_tx", 32'(TX), 1);
    check("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    count_busy(50, hi);
    check("rst_req_held", hi, 0);
    req = 1'b0;
    tick(2);

    // 9600 baud, even, 0x55; bps/din/parity changed mid-frame have no effect.
    req = 1'b1;
    tick();
    req = 1'b0;
    run_frame("t1", 5208, {1'b1, 1'b0, 8'h55, 1'b0}, 2 * 5208 + 100, 1);

    // 115200 baud, odd, 0xA7 (5 ones -> parity 0); edge mid-data dropped.
    din       = 8'hA7;
    check_sel = 1'b1;
    tick(2);
    req = 1'b1;
    tick();
    req = 1'b0;
    run_frame("t2", 434, {1'b1, 1'b0, 8'hA7, 1'b0}, 5 * 434, 2);
    count_busy(20, hi);
    check("t2_edge_dropped", hi, 0);

    // req held for 3 frame times, even, 0x3C: exactly one frame.
    din       = 8'h3C;
    check_sel = 1'b0;
    req       = 1'b1;
    run_frame("t3", 434, {1'b1, 1'b0, 8'h3C, 1'b0}, 0, 0);
    count_busy(2 * 4774, hi);
    check("t3_single_frame", hi, 0);
    req = 1'b0;
    tick(2);

    // Odd parity on 0x81 (2 ones -> parity 1), then back-to-back launch.
    din       = 8'h81;
    check_sel = 1'b1;
    req       = 1'b1;
    tick();
    req = 1'b0;
    run_frame("t4a", 434, {1'b1, 1'b1, 8'h81, 1'b0}, 0, 0);
    din = 8'h52;
    req = 1'b1;
    tick();
    check("t4b_not_yet", 32'(busy), 0);
    tick();
    check("t4b_busy", 32'(busy), 1);
    check("t4b_start", 32'(TX), 0);

    // Reset during bit 4 (data bit 3 of 0x52 = 0), req kept high.
    tick(4 * 434 + 200);
    check("t5_pre_tx", 32'(TX), 0);
    check("t5_pre_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_tx", 32'(TX), 1);
    check("t5_rst_busy", 32'(busy), 0);
    tick(3);
    rst_n = 1'b1;
    count_busy(1500, hi);
    check("t5_no_resume", hi, 0);
    check("t5_tx_idle", 32'(TX), 1);
    req = 1'b0;
    tick(2);
    req = 1'b1;
    tick();
    req = 1'b0;
    tick();
    check("t5_relaunch_busy", 32'(busy), 1);
    check("t5_relaunch_tx", 32'(TX), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
